fft_frame_sched: RTL and testbench

FFT_FRAME_SCHED -- requirements
Module: fft_frame_sched

---
 rtl/fft_frame_sched.sv | 150 +++++++++++++++
 tb/tb_fft_frame_sched.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_frame_sched.sv
// Shares one FFT engine between two sample requesters: frames are granted
// round-robin, fed through, and the engine results are routed back tagged with the owner.
module fft_frame_sched #(
    parameter int FRAME_LEN = 16,
    parameter int TIMEOUT   = 64
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] S0_AXIS_tdata,
    input  logic        S0_AXIS_tvalid,
    input  logic        S0_AXIS_tlast,
    output logic        S0_AXIS_tready,
    input  logic [31:0] S1_AXIS_tdata,
    input  logic        S1_AXIS_tvalid,
    input  logic        S1_AXIS_tlast,
    output logic        S1_AXIS_tready,
    output logic [31:0] M_AXIS_tdata,
    output logic        M_AXIS_tvalid,
    output logic        M_AXIS_tlast,
    input  logic [31:0] R_AXIS_tdata,
    input  logic        R_AXIS_tvalid,
    input  logic        R_AXIS_tlast,
    output logic [31:0] O_AXIS_tdata,
    output logic        O_AXIS_tvalid,
    output logic        O_AXIS_tlast,
    output logic        O_AXIS_tuser,
    input  logic        O_AXIS_tready,
    output logic        Busy,
    output logic        Owner,
    output logic [2:0]  Err,
    input  logic        Err_clr,
    output logic [1:0]  dbg_state
);
    // Handshake: a beat moves on a cycle with tvalid && tready. M and R carry no
    // backpressure (implicit ready); O_AXIS_tready is observed but a result is never held.
    localparam int CW = $clog2(FRAME_LEN);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FEED  = 2'd1,
        WAIT  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t        state;
    logic          owner;
    logic          rr_ptr;
    logic [CW-1:0] beat_cnt;
    logic [TW-1:0] wait_cnt;
    logic [2:0]    err;

    logic          in_feed;
    logic          in_out;
    logic          g_valid;
    logic          g_last;
    logic [31:0]   g_data;
    logic          grant_id;
    logic          at_end;
    logic          wait_expired;
    logic [2:0]    err_set;

    assign in_feed = (state == FEED);
    assign in_out  = (state == WAIT) || (state == DRAIN);

    assign g_valid = owner ? S1_AXIS_tvalid : S0_AXIS_tvalid;
    assign g_last  = owner ? S1_AXIS_tlast  : S0_AXIS_tlast;
    assign g_data  = owner ? S1_AXIS_tdata  : S0_AXIS_tdata;

    // With both requesting, the pointer decides; otherwise whoever is valid wins.
    assign grant_id = (S0_AXIS_tvalid && S1_AXIS_tvalid) ? rr_ptr : S1_AXIS_tvalid;

    assign at_end       = (beat_cnt == CW'(FRAME_LEN - 1));
    assign wait_expired = (wait_cnt == TW'(TIMEOUT - 1));

    assign S0_AXIS_tready = in_feed && !owner;
    assign S1_AXIS_tready = in_feed && owner;

    assign M_AXIS_tvalid = in_feed && g_valid;
    assign M_AXIS_tdata  = in_feed ? g_data : 32'd0;
    assign M_AXIS_tlast  = M_AXIS_tvalid && (at_end || g_last);

    assign O_AXIS_tvalid = in_out && R_AXIS_tvalid;
    assign O_AXIS_tdata  = in_out ? R_AXIS_tdata : 32'd0;
    assign O_AXIS_tlast  = O_AXIS_tvalid && R_AXIS_tlast;
    assign O_AXIS_tuser  = in_out && owner;

    assign Busy      = (state != IDLE);
    assign Owner     = owner;
    assign Err       = err;
    assign dbg_state = state;

    always_comb begin
        err_set    = 3'b000;
        err_set[0] = M_AXIS_tvalid && g_last && !at_end;
        err_set[1] = R_AXIS_tvalid && (!in_out || !O_AXIS_tready);
        err_set[2] = (state == WAIT) && !R_AXIS_tvalid && wait_expired;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            owner    <= 1'b0;
            rr_ptr   <= 1'b0;
            beat_cnt <= '0;
            wait_cnt <= '0;
            err      <= 3'b000;
        end else begin
            // A set event in the same cycle as a clear survives.
            err <= (Err_clr ? 3'b000 : err) | err_set;
            case (state)
                IDLE: begin
                    if (S0_AXIS_tvalid || S1_AXIS_tvalid) begin
                        owner    <= grant_id;
                        rr_ptr   <= !grant_id;
                        beat_cnt <= '0;
                        state    <= FEED;
                    end
                end
                FEED: begin
                    if (M_AXIS_tvalid) begin
                        if (M_AXIS_tlast) begin
                            beat_cnt <= '0;
                            wait_cnt <= '0;
                            state    <= WAIT;
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end
                end
                WAIT: begin
                    if (R_AXIS_tvalid) begin
                        state <= R_AXIS_tlast ? IDLE : DRAIN;
                    end else if (wait_expired) begin
                        state <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                DRAIN: begin
                    if (R_AXIS_tvalid && R_AXIS_tlast) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fft_frame_sched.sv
// Directed bench for fft_frame_sched: a frame-level model predicts every M and O beat,
// and literal checks pin reset, error flags, timeout timing and grant order.
`timescale 1ns/1ps
module tb_fft_frame_sched;
    localparam int FRAME_LEN = 16;
    localparam int TIMEOUT   = 64;

    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    logic [31:0] S0_AXIS_tdata = '0, S1_AXIS_tdata = '0, R_AXIS_tdata = '0;
    logic        S0_AXIS_tvalid = 0, S0_AXIS_tlast = 0, S1_AXIS_tvalid = 0, S1_AXIS_tlast = 0;
    logic        R_AXIS_tvalid = 0, R_AXIS_tlast = 0, O_AXIS_tready = 1, Err_clr = 0;
    logic        S0_AXIS_tready, S1_AXIS_tready, M_AXIS_tvalid, M_AXIS_tlast;
    logic        O_AXIS_tvalid, O_AXIS_tlast, O_AXIS_tuser, Busy, Owner;
    logic [31:0] M_AXIS_tdata, O_AXIS_tdata;
    logic [2:0]  Err;
    logic [1:0]  dbg_state;

    always #5 clk = ~clk;

    fft_frame_sched #(.FRAME_LEN(FRAME_LEN), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rstn(rstn),
        .S0_AXIS_tdata(S0_AXIS_tdata), .S0_AXIS_tvalid(S0_AXIS_tvalid),
        .S0_AXIS_tlast(S0_AXIS_tlast), .S0_AXIS_tready(S0_AXIS_tready),
        .S1_AXIS_tdata(S1_AXIS_tdata), .S1_AXIS_tvalid(S1_AXIS_tvalid),
        .S1_AXIS_tlast(S1_AXIS_tlast), .S1_AXIS_tready(S1_AXIS_tready),
        .M_AXIS_tdata(M_AXIS_tdata), .M_AXIS_tvalid(M_AXIS_tvalid), .M_AXIS_tlast(M_AXIS_tlast),
        .R_AXIS_tdata(R_AXIS_tdata), .R_AXIS_tvalid(R_AXIS_tvalid), .R_AXIS_tlast(R_AXIS_tlast),
        .O_AXIS_tdata(O_AXIS_tdata), .O_AXIS_tvalid(O_AXIS_tvalid), .O_AXIS_tlast(O_AXIS_tlast),
        .O_AXIS_tuser(O_AXIS_tuser), .O_AXIS_tready(O_AXIS_tready),
        .Busy(Busy), .Owner(Owner), .Err(Err), .Err_clr(Err_clr), .dbg_state(dbg_state)
    );

    int n_checks = 0;
    int n_fails  = 0;
    logic [32:0] exp_m[$];   // {tlast, tdata}
    logic [33:0] exp_o[$];   // {tuser, tlast, tdata}

    int s_frames[2];
    int s_idx[2];
    int s_last_at[2];
    bit gaps_on = 0;
    bit eng_on = 1;
    int eng_delay = 22;
    bit eng_pending = 0;
    int eng_wait = 0, eng_left = 0, eng_k = 0, eng_frame = 0;
    int model_eng_frame = 0;
    bit model_rr = 0;
    int cyc = 0;
    bit acc0, acc1, m_seen, m_last_seen;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive_inputs();
        bit gap;
        gap = gaps_on && (cyc % 3 == 0);
        S0_AXIS_tvalid = (s_frames[0] > 0) && !gap;
        S0_AXIS_tdata  = 32'h0001_0000 + 32'(s_idx[0]);
        S0_AXIS_tlast  = (s_idx[0] == s_last_at[0]);
        S1_AXIS_tvalid = (s_frames[1] > 0) && !gap;
        S1_AXIS_tdata  = 32'h0001_0100 + 32'(s_idx[1]);
        S1_AXIS_tlast  = (s_idx[1] == s_last_at[1]);
    endtask

    task automatic advance(input int r);
        if (s_idx[r] == s_last_at[r]) begin
            s_idx[r] = 0;
            s_frames[r]--;
        end else begin
            s_idx[r]++;
        end
    endtask

    // One clock: compare outputs at the falling edge, then update drivers after the rising edge.
    task automatic step();
        logic [32:0] em;
        logic [33:0] eo;
        @(negedge clk);
        acc0 = S0_AXIS_tvalid && S0_AXIS_tready;
        acc1 = S1_AXIS_tvalid && S1_AXIS_tready;
        m_seen = M_AXIS_tvalid;
        m_last_seen = M_AXIS_tvalid && M_AXIS_tlast;
        if (rstn) begin
            if (M_AXIS_tvalid) begin
                if (exp_m.size() == 0) begin
                    n_checks++;
                    n_fails++;
                    $display("FAIL m_beat_unexpected: got beat 0x%0h, expected no beat", M_AXIS_tdata);
                end else begin
                    em = exp_m.pop_front();
                    check("m_beat", 64'({M_AXIS_tlast, M_AXIS_tdata}), 64'(em));
                end
            end
            if (O_AXIS_tvalid) begin
                if (exp_o.size() == 0) begin
                    n_checks++;
                    n_fails++;
                    $display("FAIL o_beat_unexpected: got beat 0x%0h, expected no beat", O_AXIS_tdata);
                end else begin
                    eo = exp_o.pop_front();
                    check("o_beat", 64'({O_AXIS_tuser, O_AXIS_tlast, O_AXIS_tdata}), 64'(eo));
                end
            end
            check("s_tready_exclusive", 64'(S0_AXIS_tready & S1_AXIS_tready), 64'd0);
        end
        @(posedge clk);
        #1;
        cyc++;
        if (acc0) advance(0);
        if (acc1) advance(1);
        if (m_last_seen && eng_on) begin
            eng_pending = 1;
            eng_wait = eng_delay;
        end else if (eng_pending) begin
            eng_wait--;
            if (eng_wait == 0) begin
                eng_pending = 0;
                eng_left = FRAME_LEN;
                eng_k = 0;
            end
        end
        if (eng_left > 0) begin
            R_AXIS_tvalid = 1;
            R_AXIS_tdata  = 32'hA000_0000 + 32'(eng_frame * 256 + eng_k);
            R_AXIS_tlast  = (eng_left == 1);
            eng_k++;
            eng_left--;
            if (eng_left == 0) eng_frame++;
        end else begin
            R_AXIS_tvalid = 0;
            R_AXIS_tlast  = 0;
            R_AXIS_tdata  = '0;
        end
        drive_inputs();
    endtask

    // Frame-level model: whole frames in round-robin order among pending requesters.
    task automatic plan(input int f0, input int f1);
        int p[2];
        int g;
        int nb;
        p[0] = f0;
        p[1] = f1;
        while (p[0] > 0 || p[1] > 0) begin
            if (p[0] > 0 && p[1] > 0) g = model_rr ? 1 : 0;
            else g = (p[1] > 0) ? 1 : 0;
            model_rr = (g == 0);
            nb = (s_last_at[g] < FRAME_LEN - 1) ? s_last_at[g] + 1 : FRAME_LEN;
            for (int i = 0; i < nb; i++)
                exp_m.push_back({(i == nb - 1), 32'(32'h0001_0000 + g * 256 + i)});
            if (eng_on) begin
                for (int k = 0; k < FRAME_LEN; k++)
                    exp_o.push_back({g[0], (k == FRAME_LEN - 1),
                                     32'(32'hA000_0000 + model_eng_frame * 256 + k)});
                model_eng_frame++;
            end
            p[g]--;
        end
        s_frames[0] += f0;
        s_frames[1] += f1;
        drive_inputs();
    endtask

    task automatic run_until_done(input int max_cyc, input bit chk_wait);
        int n;
        n = 0;
        while ((exp_m.size() != 0 || exp_o.size() != 0 || Busy) && n < max_cyc) begin
            step();
            n++;
            if (chk_wait && m_last_seen) begin
                check("early_last_state_wait", 64'(dbg_state), 64'd2);
                check("early_last_s1_tready", 64'(S1_AXIS_tready), 64'd0);
            end
        end
        check("frame_done_in_budget", 64'(n < max_cyc), 64'd1);
    endtask

    task automatic clear_bench_state();
        s_frames[0] = 0; s_frames[1] = 0;
        s_idx[0] = 0; s_idx[1] = 0;
        eng_pending = 0; eng_left = 0;
        R_AXIS_tvalid = 0; R_AXIS_tlast = 0; R_AXIS_tdata = '0;
        model_rr = 0;
        exp_m.delete();
        exp_o.delete();
        model_eng_frame = eng_frame;
        drive_inputs();
    endtask

    task automatic apply_reset();
        rstn = 0;
        clear_bench_state();
        repeat (3) @(posedge clk);
        #1 rstn = 1;
    endtask

    task automatic pulse_clear();
        Err_clr = 1;
        step();
        Err_clr = 0;
        check("err_after_clear", 64'(Err), 64'd0);
    endtask

    initial begin
        int n;
        s_last_at[0] = FRAME_LEN - 1;
        s_last_at[1] = FRAME_LEN - 1;
        s_frames[0] = 0; s_frames[1] = 0;
        s_idx[0] = 0; s_idx[1] = 0;
        #2 rstn = 0;
        #1;
        check("rst_busy", 64'(Busy), 64'd0);
        check("rst_err_owner", 64'({Err, Owner}), 64'd0);
        check("rst_treadys", 64'({S0_AXIS_tready, S1_AXIS_tready}), 64'd0);
        check("rst_m_stream", 64'({M_AXIS_tvalid, M_AXIS_tlast}), 64'd0);
        check("rst_o_stream", 64'({O_AXIS_tvalid, O_AXIS_tlast}), 64'd0);
        apply_reset();

        // Single S0 frame, engine answers 22 cycles after the last sample.
        plan(1, 0);
        check("model_first_m", 64'(exp_m[0]), 64'h0_0001_0000);
        check("model_last_m", 64'(exp_m[15]), 64'h1_0001_000F);
        check("model_last_o", 64'(exp_o[15]), 64'h1_A000_000F);
        run_until_done(200, 0);
        check("basic_err", 64'(Err), 64'd0);
        check("basic_busy", 64'(Busy), 64'd0);
        check("basic_owner", 64'(Owner), 64'd0);

        // Both requesters contend from reset.
        apply_reset();
        plan(2, 1);
        check("model_grant_order", 64'({exp_o[0][33], exp_o[16][33], exp_o[32][33]}), 64'b010);
        check("model_s1_first_m", 64'(exp_m[16]), 64'h0_0001_0100);
        run_until_done(400, 0);
        check("rr_err", 64'(Err), 64'd0);
        check("rr_owner_last", 64'(Owner), 64'd0);

        // S1 ends its frame early at beat 9.
        s_last_at[1] = 9;
        plan(0, 1);
        check("model_early_len", 64'(exp_m.size()), 64'd10);
        check("model_early_last", 64'(exp_m[9]), 64'h1_0001_0109);
        run_until_done(200, 1);
        check("early_err", 64'(Err), 64'b001);
        check("early_owner", 64'(Owner), 64'd1);
        pulse_clear();
        s_last_at[1] = FRAME_LEN - 1;

        // Engine never answers.
        eng_on = 0;
        plan(1, 0);
        n = 0;
        m_last_seen = 0;
        while (!m_last_seen && n < 100) begin
            step();
            n++;
        end
        check("timeout_tlast_seen", 64'(m_last_seen), 64'd1);
        repeat (TIMEOUT - 1) step();
        check("timeout_busy_before", 64'({Busy, Err}), 64'b1000);
        step();
        check("timeout_busy_after", 64'(Busy), 64'd0);
        check("timeout_err", 64'(Err), 64'b100);
        pulse_clear();
        eng_on = 1;

        // Results presented with O_AXIS_tready low; requester inserts gaps.
        O_AXIS_tready = 0;
        gaps_on = 1;
        plan(1, 0);
        run_until_done(300, 0);
        check("overrun_err", 64'(Err), 64'b010);
        O_AXIS_tready = 1;
        gaps_on = 0;
        pulse_clear();

        // Reset in the middle of a frame.
        plan(1, 0);
        n = 0;
        while (n < 8) begin
            step();
            if (m_seen) n++;
        end
        rstn = 0;
        #1;
        check("midrst_m", 64'({M_AXIS_tvalid, M_AXIS_tlast, M_AXIS_tdata}), 64'd0);
        check("midrst_o", 64'({O_AXIS_tvalid, O_AXIS_tlast, O_AXIS_tuser, O_AXIS_tdata}), 64'd0);
        check("midrst_ctl", 64'({S0_AXIS_tready, S1_AXIS_tready, Busy, Owner, Err}), 64'd0);
        clear_bench_state();
        @(posedge clk);
        @(posedge clk);
        #1 rstn = 1;
        repeat (5) step();
        check("midrst_idle_busy", 64'(Busy), 64'd0);
        plan(1, 0);
        run_until_done(200, 0);
        check("midrst_restart_err", 64'(Err), 64'd0);

        check("m_queue_empty", 64'(exp_m.size()), 64'd0);
        check("o_queue_empty", 64'(exp_o.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
